// File: rtl/bus_arbiter_nm_pkg.sv
// Shared types and constants for the N-master round-robin memory arbiter.
package bus_arbiter_nm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] BURST_NORMAL = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;

  // Any non-normal code (INCR, WRAP, or the unused 2'b11) runs a full burst.
  function automatic logic is_burst(input logic [1:0] burst);
    return burst != BURST_NORMAL;
  endfunction

endpackage

// File: rtl/bus_arbiter_nm_if.sv
// Bundle of the per-master request ports and the single memory port.
interface bus_arbiter_nm_if #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32
);
  // Handshake: a master holds req and its fields stable until it sees ack in the
  // same cycle; stall means "request seen, not served this cycle"; err is only
  // meaningful together with ack. The memory side uses the same req/ready/stall rules.
  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS-1:0]        m_write;
  logic [N_MASTERS*AW-1:0]     m_addr;
  logic [N_MASTERS*DW-1:0]     m_wdata;
  logic [N_MASTERS*DW/8-1:0]   m_bstrobe;
  logic [N_MASTERS*2-1:0]      m_burst;
  logic [N_MASTERS-1:0]        m_allow;
  logic [DW-1:0]               m_rdata;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS-1:0]        m_stall;
  logic [N_MASTERS-1:0]        m_err;

  logic                        mem_req;
  logic                        mem_write;
  logic [AW-1:0]               mem_addr;
  logic [DW-1:0]               mem_wdata;
  logic [DW/8-1:0]             mem_bstrobe;
  logic [1:0]                  mem_burst;
  logic [DW-1:0]               mem_rdata;
  logic                        mem_ready;
  logic                        mem_stall;

  modport arb (
    input  m_req, m_write, m_addr, m_wdata, m_bstrobe, m_burst, m_allow,
    input  mem_rdata, mem_ready, mem_stall,
    output m_rdata, m_ack, m_stall, m_err,
    output mem_req, mem_write, mem_addr, mem_wdata, mem_bstrobe, mem_burst
  );

  modport master (
    output m_req, m_write, m_addr, m_wdata, m_bstrobe, m_burst, m_allow,
    input  m_rdata, m_ack, m_stall, m_err
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata, mem_bstrobe, mem_burst,
    output mem_rdata, mem_ready, mem_stall
  );

endinterface

// File: rtl/bus_arbiter_nm_rr_arbiter.sv
// Combinational cyclic priority pick: first requester found searching from ptr+1.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    cand  = '0;
    // Farthest offset first so the nearest requester after ptr overrides it.
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        gnt   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_nm.sv
// N-master round-robin memory arbiter with burst hold and per-master MPU gate.
// Optional bus watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter_nm
  import bus_arbiter_nm_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  bus_arbiter_nm_if.arb    bus,
  output state_t           state_dbg
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int BW = $clog2(BURST_LEN);
  localparam int SW = DW / 8;

  if (N_MASTERS < 2 || N_MASTERS > 8 || BURST_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bus_arbiter_nm: unsupported parameter set");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d, rr_q, rr_d, pick;
  logic            pick_valid;
  logic [1:0]      burst_q, burst_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            done, tmo;

  logic [N_MASTERS-1:0] ack, err, stall;
  logic [DW-1:0]        rdata, mwdata;
  logic                 mreq, mwrite;
  logic [AW-1:0]        maddr;
  logic [SW-1:0]        mstrb;
  logic [1:0]           mburst;

  rr_arbiter #(.N(N_MASTERS), .IW(IW)) u_rr (
    .req   (bus.m_req),
    .ptr   (rr_q),
    .gnt   (pick),
    .valid (pick_valid)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_BUSY || bus.mem_ready) wdog_q <= '0;
    else                                           wdog_q <= wdog_q + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive BUSY cycle without mem_ready.
  assign tmo = (state_q == ST_BUSY) && !bus.mem_ready && (wdog_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign done = bus.mem_ready && (!is_burst(burst_q) || beat_q == BW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      burst_q <= BURST_NORMAL;
      rr_q    <= IW'(N_MASTERS - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    ack     = '0;
    err     = '0;
    stall   = bus.m_req;
    rdata   = '0;
    mreq    = 1'b0;
    mwrite  = 1'b0;
    maddr   = '0;
    mwdata  = '0;
    mstrb   = '0;
    mburst  = BURST_NORMAL;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick;
          burst_d = bus.m_burst[pick*2 +: 2];
          state_d = bus.m_allow[pick] ? ST_BUSY : ST_ERR;
        end
      end
      ST_BUSY: begin
        mwrite       = bus.m_write[gnt_q];
        maddr        = bus.m_addr[gnt_q*AW +: AW];
        mwdata       = bus.m_wdata[gnt_q*DW +: DW];
        mstrb        = bus.m_bstrobe[gnt_q*SW +: SW];
        mburst       = burst_q;
        stall[gnt_q] = bus.mem_stall;
        if (tmo) begin
          ack[gnt_q] = 1'b1;
          err[gnt_q] = 1'b1;
          state_d    = ST_IDLE;
          rr_d       = gnt_q;
          beat_d     = '0;
        end else begin
          // Grant is held even if the master drops req mid-burst; memory just idles.
          mreq       = bus.m_req[gnt_q];
          ack[gnt_q] = bus.mem_ready;
          rdata      = bus.mem_rdata;
          if (done) begin
            state_d = ST_IDLE;
            rr_d    = gnt_q;
            beat_d  = '0;
          end else if (bus.mem_ready) begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        stall[gnt_q] = 1'b0;
        ack[gnt_q]   = 1'b1;
        err[gnt_q]   = 1'b1;
        state_d      = ST_IDLE;
        rr_d         = gnt_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset abandons any transaction in flight: nothing may be acknowledged.
    if (rst) begin
      ack    = '0;
      err    = '0;
      stall  = '0;
      rdata  = '0;
      mreq   = 1'b0;
      mwrite = 1'b0;
      maddr  = '0;
      mwdata = '0;
      mstrb  = '0;
      mburst = BURST_NORMAL;
    end
  end

  assign bus.m_ack       = ack;
  assign bus.m_err       = err;
  assign bus.m_stall     = stall;
  assign bus.m_rdata     = rdata;
  assign bus.mem_req     = mreq;
  assign bus.mem_write   = mwrite;
  assign bus.mem_addr    = maddr;
  assign bus.mem_wdata   = mwdata;
  assign bus.mem_bstrobe = mstrb;
  assign bus.mem_burst   = mburst;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Self-checking bench for bus_arbiter_nm: scripted masters, echo memory, beat scoreboard.
module tb_bus_arbiter_nm;
  import bus_arbiter_nm_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int BL  = 4;
  localparam int TMO = 8;
  localparam int EW  = 2 * N + DW;
  localparam logic [DW-1:0] RD_KEY = 32'hA5A5_0F0F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_nm_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();
  state_t state_dbg;

  bus_arbiter_nm #(
    .N_MASTERS(N), .AW(AW), .DW(DW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- master-side drive ----------------
  logic [N-1:0]  req_v, write_v, allow_v;
  logic [AW-1:0] addr_v  [N];
  logic [DW-1:0] wdata_v [N];
  logic [SW-1:0] strb_v  [N];
  logic [1:0]    burst_v [N];
  int            beats_left [N];
  logic          ready_v, alt_en;

  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] wdata_p;
  logic [N*SW-1:0] strb_p;
  logic [N*2-1:0]  burst_p;

  always_comb begin
    addr_p  = '0;
    wdata_p = '0;
    strb_p  = '0;
    burst_p = '0;
    for (int i = 0; i < N; i++) begin
      addr_p[i*AW +: AW]  = addr_v[i];
      wdata_p[i*DW +: DW] = wdata_v[i];
      strb_p[i*SW +: SW]  = strb_v[i];
      burst_p[i*2 +: 2]   = burst_v[i];
    end
  end

  assign bus.m_req     = req_v;
  assign bus.m_write   = write_v;
  assign bus.m_allow   = allow_v;
  assign bus.m_addr    = addr_p;
  assign bus.m_wdata   = wdata_p;
  assign bus.m_bstrobe = strb_p;
  assign bus.m_burst   = burst_p;

  // Memory returns a fixed function of the address it is presented with.
  assign bus.mem_rdata = bus.mem_addr ^ RD_KEY;
  assign bus.mem_ready = ready_v & bus.mem_req;
  assign bus.mem_stall = bus.mem_req & ~ready_v;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] ack_last;
  int req_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input int i, input logic e, input logic [AW-1:0] addr);
    logic [N-1:0]  oh;
    logic [DW-1:0] rd;
    oh    = '0;
    oh[i] = 1'b1;
    rd    = e ? '0 : (addr ^ RD_KEY);
    exp_q.push_back({oh, (e ? oh : {N{1'b0}}), rd});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ack_last <= '0;
    end else begin
      ack_last <= bus.m_ack;
      if (bus.mem_req) req_cycles <= req_cycles + 1;
      if (bus.m_ack != '0) begin
        if (exp_q.size() == 0) check("sb_unexpected", 64'(bus.m_ack), 64'(0));
        else check("sb_beat", 64'({bus.m_ack, bus.m_err, bus.m_rdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                       input logic [1:0] burst, input logic allow);
    write_v[i]    = wr;
    addr_v[i]     = addr;
    wdata_v[i]    = wdata;
    strb_v[i]     = strb;
    burst_v[i]    = burst;
    allow_v[i]    = allow;
    beats_left[i] = (!allow || burst == BURST_NORMAL) ? 1 : BL;
    req_v[i]      = 1'b1;
  endtask

  // One clock: masters that were acked advance their address, finish, or keep going.
  task automatic adv();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_last[i] && beats_left[i] > 0) begin
        beats_left[i]--;
        addr_v[i] = addr_v[i] + 4;
        if (beats_left[i] == 0) req_v[i] = 1'b0;
      end
    end
    if (alt_en) ready_v = ~ready_v;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_v   = '0;
    allow_v = '1;
    ready_v = 1'b1;
    alt_en  = 1'b0;
    for (int i = 0; i < N; i++) beats_left[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (req_v == '0 && state_dbg == ST_IDLE) break;
      if (k >= budget) begin
        check({tag, "_timeout"}, 64'(1), 64'(0));
        break;
      end
      k++;
      adv();
    end
    adv();
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acks1;
    int rc0;
    req_v   = '1;
    write_v = '0;
    allow_v = '1;
    ready_v = 1'b1;
    alt_en  = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_v[i] = '0; wdata_v[i] = '0; strb_v[i] = '0; burst_v[i] = BURST_NORMAL; beats_left[i] = 0;
    end

    // Reset state, with every master requesting during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_ack_err_stall", 64'({bus.m_ack, bus.m_err, bus.m_stall}), 64'(0));
    check("rst_rdata", 64'(bus.m_rdata), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));

    // A: two single-beat masters from reset, master 0 first, 1-cycle grant latency.
    do_reset();
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
    issue(1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hA, BURST_NORMAL, 1'b1);
    push_beat(0, 1'b0, 32'h100);
    push_beat(1, 1'b0, 32'h200);
    @(negedge clk);
    check("a_idle_mem_req", 64'(bus.mem_req), 64'(0));
    check("a_idle_stall", 64'(bus.m_stall), 64'(4'b0011));
    adv(); @(negedge clk);
    check("a_m0_mem_req", 64'(bus.mem_req), 64'(1));
    check("a_m0_addr", 64'(bus.mem_addr), 64'(32'h100));
    check("a_m0_write", 64'(bus.mem_write), 64'(0));
    check("a_m0_stall", 64'(bus.m_stall), 64'(4'b0010));
    adv(); @(negedge clk);
    check("a_bubble_state", 64'(state_dbg), 64'(ST_IDLE));
    check("a_bubble_mem_req", 64'(bus.mem_req), 64'(0));
    adv(); @(negedge clk);
    check("a_m1_write", 64'(bus.mem_write), 64'(1));
    check("a_m1_addr", 64'(bus.mem_addr), 64'(32'h200));
    check("a_m1_wdata", 64'(bus.mem_wdata), 64'(32'hDEAD_BEEF));
    check("a_m1_strobe", 64'(bus.mem_bstrobe), 64'(4'hA));
    adv();
    drain("a", 20);

    // B: four masters contending, order 0,1,2,3 then master 0 again.
    do_reset();
    for (int i = 0; i < N; i++) begin
      issue(i, 1'b0, 32'h1000 + 32'(i) * 32'h100, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
      push_beat(i, 1'b0, 32'h1000 + 32'(i) * 32'h100);
    end
    push_beat(0, 1'b0, 32'h2000);
    @(negedge clk);
    check("b_idle_stall", 64'(bus.m_stall), 64'(4'b1111));
    adv(); @(negedge clk);
    check("b_g0_stall", 64'(bus.m_stall), 64'(4'b1110));
    check("b_g0_addr", 64'(bus.mem_addr), 64'(32'h1000));
    adv(); @(negedge clk);
    check("b_gap_stall", 64'(bus.m_stall), 64'(4'b1110));
    adv(); @(negedge clk);
    check("b_g1_stall", 64'(bus.m_stall), 64'(4'b1100));
    check("b_g1_addr", 64'(bus.mem_addr), 64'(32'h1100));
    adv();
    issue(0, 1'b0, 32'h2000, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
    drain("b", 40);

    // C: master 1 INCR burst with alternating mem_ready; master 0 waits throughout.
    do_reset();
    issue(1, 1'b0, 32'h400, 32'h0, 4'hF, BURST_INCR, 1'b1);
    for (int b = 0; b < BL; b++) push_beat(1, 1'b0, 32'h400 + 32'(b) * 32'd4);
    push_beat(0, 1'b0, 32'h300);
    adv();
    issue(0, 1'b0, 32'h300, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
    alt_en = 1'b1;
    acks1  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!req_v[1]) break;
      if (bus.m_ack[1]) acks1++;
      check("c_stall0", 64'(bus.m_stall[0]), 64'(1));
      check("c_burst_code", 64'(bus.mem_burst), 64'(BURST_INCR));
      adv();
    end
    check("c_idle_after_burst", 64'(state_dbg), 64'(ST_IDLE));
    check("c_m1_acks", 64'(acks1), 64'(BL));
    alt_en  = 1'b0;
    adv();
    ready_v = 1'b1;
    drain("c", 20);

    // D: MPU-denied read and denied burst each get one local error beat.
    do_reset();
    rc0 = req_cycles;
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, BURST_NORMAL, 1'b0);
    push_beat(0, 1'b1, 32'h0);
    adv(); @(negedge clk);
    check("d_state_err", 64'(state_dbg), 64'(ST_ERR));
    check("d_err", 64'(bus.m_err), 64'(4'b0001));
    check("d_rdata", 64'(bus.m_rdata), 64'(0));
    check("d_mem_req", 64'(bus.mem_req), 64'(0));
    adv(); @(negedge clk);
    check("d_back_idle", 64'(state_dbg), 64'(ST_IDLE));
    adv();
    issue(1, 1'b0, 32'h1800, 32'h0, 4'hF, BURST_WRAP, 1'b0);
    push_beat(1, 1'b1, 32'h0);
    drain("d", 10);
    check("d_no_mem_req", 64'(req_cycles - rc0), 64'(0));

    // E: reset during beat 2 abandons the burst; master 0 wins the next contention.
    do_reset();
    issue(2, 1'b0, 32'h500, 32'h0, 4'hF, BURST_INCR, 1'b1);
    push_beat(2, 1'b0, 32'h500);
    adv(); @(negedge clk);
    check("e_beat1_busy", 64'(state_dbg), 64'(ST_BUSY));
    adv();
    rst   = 1'b1;
    req_v = '0;
    for (int i = 0; i < N; i++) beats_left[i] = 0;
    @(negedge clk);
    check("e_rst_ack", 64'(bus.m_ack), 64'(0));
    check("e_rst_mem", 64'({bus.mem_req, bus.mem_addr}), 64'(0));
    adv();
    rst = 1'b0;
    @(negedge clk);
    check("e_post_state", 64'(state_dbg), 64'(ST_IDLE));
    check("e_post_outs", 64'({bus.m_ack, bus.m_err, bus.m_stall, bus.mem_req}), 64'(0));
    adv();
    issue(3, 1'b0, 32'h700, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
    issue(0, 1'b0, 32'h600, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
    push_beat(0, 1'b0, 32'h600);
    push_beat(3, 1'b0, 32'h700);
    drain("e", 20);

`ifdef BUS_ARBITER_TIMEOUT_EN
    // F: memory never ready; watchdog errors out on the 8th BUSY cycle.
    do_reset();
    ready_v = 1'b0;
    issue(0, 1'b0, 32'h800, 32'h0, 4'hF, BURST_NORMAL, 1'b1);
    push_beat(0, 1'b1, 32'h0);
    adv();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k < TMO) begin
        check("f_wait_no_ack", 64'(bus.m_ack), 64'(0));
      end else begin
        check("f_tmo_err", 64'(bus.m_err), 64'(4'b0001));
        check("f_tmo_mem_req", 64'(bus.mem_req), 64'(0));
      end
      adv();
    end
    @(negedge clk);
    check("f_idle", 64'(state_dbg), 64'(ST_IDLE));
    adv();
    ready_v = 1'b1;
    drain("f", 10);
`endif

    check("final_sb_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_nm.md
Name: bus_arbiter_nm

Overview:
- Parametrised successor to the fixed two-port (instruction/data) memory interconnect.
- Arbitrates N_MASTERS identical REQ/ACK/STALL master ports onto one memory port using round-robin priority.
- Holds a grant for the full burst; gates each request with a per-master MPU allow bit and answers denied requests with a local error response.
- Sits between the cpu/DMA masters and the DATA_MEMORY slave in riscv_platform.

Parameters:
- N_MASTERS, 2, number of master ports (2..8).
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- BURST_LEN, 4, beats per INCR/WRAP burst (BURST != 2'b00).
- TIMEOUT_CYCLES, 64, cycles without mem_ready before error (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_req  in  N_MASTERS  per-master request
- m_write  in  N_MASTERS  per-master write (1) / read (0)
- m_addr  in  N_MASTERS*AW  packed addresses, master i at [i*AW +: AW]
- m_wdata  in  N_MASTERS*DW  packed write data
- m_bstrobe  in  N_MASTERS*DW/8  packed byte strobes
- m_burst  in  N_MASTERS*2  packed burst type: 00 normal, 01 INCR, 10 WRAP
- m_allow  in  N_MASTERS  MPU permits this access (sampled at grant)
- m_rdata  out  DW  shared read data, valid for the master whose m_ack is high
- m_ack  out  N_MASTERS  per-master beat acknowledge
- m_stall  out  N_MASTERS  per-master stall
- m_err  out  N_MASTERS  access error, qualified by m_ack
- mem_req  out  1  memory request
- mem_write  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_bstrobe  out  DW/8  memory byte strobes
- mem_burst  out  2  memory burst type
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory beat acknowledge
- mem_stall  in  1  memory stall

Behaviour:
- Reset values:
  - State IDLE.
  - rr_ptr = N_MASTERS-1, so master 0 wins the first contention.
  - beat_cnt = 0.
  - All mem_* outputs 0; m_ack, m_err, m_rdata 0; m_stall 0.
- Reset asserted mid-transaction abandons the transaction; no ack is issued to any master.
- State IDLE:
  - If no m_req is set, stay in IDLE.
  - Otherwise select the first requesting index found by searching cyclically from rr_ptr+1.
  - Register the winner as gnt_idx and its burst type into gnt_burst.
  - Go to ERR if m_allow[gnt_idx]=0, else to BUSY.
- Grant latency: mem_req is first asserted in the cycle after the request is sampled (1 cycle).
- State BUSY:
  - mem_* is driven combinationally from the gnt_idx master's fields; mem_req = m_req[gnt_idx].
  - m_ack[gnt_idx] = mem_ready and m_rdata = mem_rdata, same cycle, no added latency.
  - m_stall[gnt_idx] = mem_stall.
  - beat_cnt increments on each mem_ready.
  - The transaction is done on mem_ready when gnt_burst == 00, or when beat_cnt == BURST_LEN-1 for a burst.
  - On done: next state IDLE, rr_ptr <= gnt_idx, beat_cnt <= 0.
- State ERR (one cycle):
  - m_ack[gnt_idx] = 1, m_err[gnt_idx] = 1, m_rdata = 0; mem_req stays 0.
  - Next state IDLE, rr_ptr <= gnt_idx.
  - A denied burst is terminated after this single error beat.
- Non-granted masters: m_stall[i] = m_req[i] whenever i != gnt_idx or state == IDLE.
- Burst addressing: the master advances its own address; the block forwards m_addr unchanged each beat.
- Grant is held until done even if the granted master drops m_req mid-burst; mem_req then goes low and the block waits.
- No back-to-back bubble removal: a master always sees at least 1 IDLE cycle between its transactions, which gives fairness.
- Widths: beat_cnt is $clog2(BURST_LEN) bits; gnt_idx and rr_ptr are $clog2(N_MASTERS) bits, with wrap at N_MASTERS-1 → 0.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit watchdog counts BUSY cycles with mem_ready=0 and resets to 0 on each mem_ready.
  - When the count reaches TIMEOUT_CYCLES, the block drives m_ack[gnt_idx]=1 and m_err[gnt_idx]=1 for one cycle, deasserts mem_req, and returns to IDLE with rr_ptr <= gnt_idx.
- Undefined: no watchdog; BUSY waits indefinitely.

Decomposition:
- Shared package/defines (alongside defines.v):
  - State encodings: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_ERR=2'd2.
  - Burst codes: BURST_NORMAL=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
- One natural sub-module: rr_arbiter (combinational cyclic priority pick from req vector and rr_ptr, producing gnt_idx and a valid flag).
- Mux/demux and FSM stay in bus_arbiter_nm.

Test Plan:
- N=2: m_req=2'b11 from reset → master 0 granted first. After its single beat (mem_ready=1), master 1 granted; mem_req rises 1 cycle after each IDLE sample.
- N=4, all four requesting continuously → grant order 0,1,2,3,0; m_stall high for every non-granted requester.
- Master 1 INCR burst, BURST_LEN=4, mem_ready high on alternating cycles → exactly 4 m_ack[1] pulses; grant held; master 0 stalled throughout; IDLE after beat 4.
- m_allow[0]=0 on a read to 0x0000_1000 → one cycle with m_ack[0]=1, m_err[0]=1, m_rdata=0; mem_req never asserted.
- rst asserted during beat 2 of a burst → next cycle all outputs 0, state IDLE; master 0 wins the next contention.
- BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready held 0 → error ack on cycle 8 of BUSY, then IDLE.
